// File: rtl/aes_pkg.sv
// Shared types, tables and GF(2^8) helpers for the byte-serial AES
// inverse cipher.
package aes_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_ROUND,
    S_MIX,
    S_OUT
  } state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplier is a 4-bit constant (9, 11, 13 or 14)
  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [3:0] m
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // InvShiftRows as a read address: row r rotates right by r
  function automatic logic [3:0] inv_shift_src(input logic [3:0] idx);
    logic [1:0] r;
    logic [1:0] c;
    r = idx[1:0];
    c = idx[3:2];
    return {2'(c - r), r};
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column.
// Row r of the column sits in bits [8r+7:8r].
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0;
  logic [7:0] w_a1;
  logic [7:0] w_a2;
  logic [7:0] w_a3;

  assign w_a0 = i_col[7:0];
  assign w_a1 = i_col[15:8];
  assign w_a2 = i_col[23:16];
  assign w_a3 = i_col[31:24];

  assign o_col[7:0]   = gmul(w_a0, 4'd14) ^ gmul(w_a1, 4'd11)
                      ^ gmul(w_a2, 4'd13) ^ gmul(w_a3, 4'd9);
  assign o_col[15:8]  = gmul(w_a0, 4'd9)  ^ gmul(w_a1, 4'd14)
                      ^ gmul(w_a2, 4'd11) ^ gmul(w_a3, 4'd13);
  assign o_col[23:16] = gmul(w_a0, 4'd13) ^ gmul(w_a1, 4'd9)
                      ^ gmul(w_a2, 4'd14) ^ gmul(w_a3, 4'd11);
  assign o_col[31:24] = gmul(w_a0, 4'd11) ^ gmul(w_a1, 4'd13)
                      ^ gmul(w_a2, 4'd9)  ^ gmul(w_a3, 4'd14);

endmodule

// File: rtl/aes_decrypt_serial.sv
// Byte-serial AES inverse cipher; round keys are fetched byte by byte
// from an external key schedule indexed by key_round.
module aes_decrypt_serial
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_byte,
  output logic [3:0] key_round,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_decrypt_serial: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_L  = 4'(NR);
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  state_t       r_state;
  logic [127:0] r_st;
  logic [127:0] r_wk;
  logic [3:0]   r_idx;
  logic [3:0]   r_rnd;

  state_t       w_state_nx;
  logic [127:0] w_st_nx;
  logic [127:0] w_wk_nx;
  logic [3:0]   w_idx_nx;
  logic [3:0]   w_rnd_nx;

  logic [3:0]   w_src;
  logic [7:0]   w_sbox_in;
  logic [7:0]   w_sub;
  logic [31:0]  w_col_in;
  logic [31:0]  w_col_out;

  assign w_src     = inv_shift_src(r_idx);
  assign w_sbox_in = r_st[{w_src, 3'b000} +: 8];
  assign w_sub     = INV_SBOX[w_sbox_in] ^ key_byte;
  assign w_col_in  = r_st[{r_idx[1:0], 5'b00000} +: 32];

  inv_mix_column u_imc (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_LOAD;
      r_st    <= '0;
      r_wk    <= '0;
      r_idx   <= '0;
      r_rnd   <= NR_L;
    end else begin
      r_state <= w_state_nx;
      r_st    <= w_st_nx;
      r_wk    <= w_wk_nx;
      r_idx   <= w_idx_nx;
      r_rnd   <= w_rnd_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_st_nx    = r_st;
    w_wk_nx    = r_wk;
    w_idx_nx   = r_idx;
    w_rnd_nx   = r_rnd;
    in_ready   = 1'b0;
    key_ready  = 1'b0;
    out_valid  = 1'b0;
    out_byte   = 8'h00;
    unique case (r_state)
      S_LOAD: begin
        // Ciphertext and round key NR are consumed as a pair
        in_ready  = key_valid;
        key_ready = in_valid;
        if (in_valid && key_valid) begin
          w_st_nx[{r_idx, 3'b000} +: 8] = in_byte ^ key_byte;
          w_idx_nx = r_idx + 4'd1;
          if (r_idx == 4'd15) begin
            w_rnd_nx   = NR_M1;
            w_state_nx = S_ROUND;
          end
        end
      end
      S_ROUND: begin
        key_ready = 1'b1;
        if (key_valid) begin
          w_wk_nx[{r_idx, 3'b000} +: 8] = w_sub;
          w_idx_nx = r_idx + 4'd1;
          if (r_idx == 4'd15) begin
            w_st_nx    = w_wk_nx;
            w_state_nx = (r_rnd == 4'd0) ? S_OUT : S_MIX;
          end
        end
      end
      S_MIX: begin
        w_st_nx[{r_idx[1:0], 5'b00000} +: 32] = w_col_out;
        w_idx_nx = r_idx + 4'd1;
        if (r_idx == 4'd3) begin
          w_idx_nx   = 4'd0;
          w_rnd_nx   = r_rnd - 4'd1;
          w_state_nx = S_ROUND;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_byte  = r_st[{r_idx, 3'b000} +: 8];
        if (out_ready) begin
          w_idx_nx = r_idx + 4'd1;
          if (r_idx == 4'd15) begin
            w_rnd_nx   = NR_L;
            w_state_nx = S_LOAD;
          end
        end
      end
      default: ;
    endcase
  end

  // rnd already equals NR in LOAD, so it doubles as the key index
  assign key_round = r_rnd;
  assign busy      = !(r_state == S_LOAD && r_idx == 4'd0);

endmodule

// File: tb/tb_aes_decrypt_serial.sv
// Scoreboard bench for aes_decrypt_serial at NR=10 and NR=14 using the
// FIPS-197 C.1 / C.3 vectors and a locally derived key schedule.
`timescale 1ns/1ps
module tb_aes_decrypt_serial;

  localparam int NRV [2] = '{10, 14};
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       in_valid [2];
  logic [7:0] in_byte [2];
  logic       key_valid [2];
  logic [7:0] key_byte [2];
  logic       out_ready [2];
  logic       in_ready [2];
  logic       key_ready [2];
  logic [3:0] key_round [2];
  logic       out_valid [2];
  logic [7:0] out_byte [2];
  logic       busy [2];

  aes_decrypt_serial #(.NR(10)) u_dut128 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_byte(in_byte[0]),
    .key_valid(key_valid[0]), .key_ready(key_ready[0]),
    .key_byte(key_byte[0]), .key_round(key_round[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_byte(out_byte[0]), .busy(busy[0])
  );

  aes_decrypt_serial #(.NR(14)) u_dut256 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_byte(in_byte[1]),
    .key_valid(key_valid[1]), .key_ready(key_ready[1]),
    .key_byte(key_byte[1]), .key_round(key_round[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_byte(out_byte[1]), .busy(busy[1])
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Forward S-box and key expansion derived from GF(2^8) arithmetic
  logic [7:0]  sbox [256];
  logic [31:0] w [60];
  logic [7:0]  rk [2][15][16];

  function automatic logic [7:0] tmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
              ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input int d, input logic [255:0] key,
                        input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      for (int j = 0; j < 16; j++)
        rk[d][r][j] = w[4 * r + j / 4][31 - 8 * (j % 4) -: 8];
  endtask

  // External key schedule: tracks which byte of the round key is next
  logic [3:0] kj [2];
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      kj[0] <= 4'd0;
      kj[1] <= 4'd0;
    end else begin
      for (int d = 0; d < 2; d++)
        if (key_valid[d] && key_ready[d]) kj[d] <= kj[d] + 4'd1;
    end
  end
  assign key_byte[0] = rk[0][key_round[0]][kj[0]];
  assign key_byte[1] = rk[1][key_round[1]][kj[1]];

  // Handshake drivers: random gaps on key_valid and out_ready
  int kv_gap [2] = '{0, 0};
  int or_gap [2] = '{0, 0};
  bit kv_off [2] = '{1'b0, 1'b0};
  initial begin
    for (int d = 0; d < 2; d++) begin
      key_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
    end
    forever begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        key_valid[d] = !kv_off[d] &&
                       (int'($urandom_range(0, 99)) >= kv_gap[d]);
        out_ready[d] = (int'($urandom_range(0, 99)) >= or_gap[d]);
      end
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [7:0] b;
    logic       chk;
  } exp_t;
  exp_t sbq0 [$];
  exp_t sbq1 [$];

  function automatic logic [7:0] byte_of(input logic [127:0] v,
                                         input int j);
    return v[127 - 8 * j -: 8];
  endfunction

  task automatic push_exp(input int d, input logic [127:0] pt,
                          input logic chk);
    exp_t e;
    for (int j = 0; j < 16; j++) begin
      e.b = byte_of(pt, j);
      e.chk = chk;
      if (d == 0) sbq0.push_back(e);
      else sbq1.push_back(e);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? sbq0.size() : sbq1.size();
  endfunction

  // Monitor
  logic       hold_v [2] = '{1'b0, 1'b0};
  logic [7:0] hold_b [2];
  int         kf [2] = '{0, 0};
  int         last_ofire [2] = '{0, 0};
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          hold_v[d] = 1'b0;
          kf[d] = 0;
        end else begin
          if (hold_v[d])
            check($sformatf("out_hold%0d", d),
                  {23'h0, out_valid[d], out_byte[d]},
                  {23'h0, 1'b1, hold_b[d]});
          if (key_valid[d] && key_ready[d]) begin
            check($sformatf("key_round%0d", d), 32'(key_round[d]),
                  32'(NRV[d] - kf[d] / 16));
            kf[d] = (kf[d] + 1) % (16 * (NRV[d] + 1));
          end
          if (out_valid[d] && out_ready[d]) begin
            last_ofire[d] = cyc;
            if (qsize(d) == 0) begin
              check($sformatf("unexpected_out%0d", d), 32'd1, 32'd0);
            end else begin
              e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
              if (e.chk)
                check($sformatf("plaintext%0d", d), 32'(out_byte[d]),
                      32'(e.b));
            end
          end
          hold_v[d] = out_valid[d] && !out_ready[d];
          hold_b[d] = out_byte[d];
        end
      end
    end
  end

  int fire_cyc [2] = '{0, 0};

  task automatic send_block(input int d, input logic [127:0] ct);
    int j;
    int t;
    j = 0;
    t = 0;
    while (j < 16 && t < 1000) begin
      @(negedge clock);
      in_valid[d] = 1'b1;
      in_byte[d] = byte_of(ct, j);
      #1;
      if (in_ready[d]) begin
        if (j == 0) fire_cyc[d] = cyc;
        j++;
      end
      t++;
    end
    if (j < 16) check("send_timeout", 32'(j), 32'd16);
    @(negedge clock);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_ov(input int d, output int at);
    int t;
    at = -1;
    t = 0;
    while (at < 0 && t < 2000) begin
      @(negedge clock);
      #1;
      if (out_valid[d]) at = cyc;
      t++;
    end
    if (at < 0) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input int d);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    while (!done && t < 3000) begin
      @(negedge clock);
      #2;
      done = (qsize(d) == 0) && !out_valid[d];
      t++;
    end
    if (!done) check("drain_timeout", 32'(qsize(d)), 32'd0);
  endtask

  task automatic run_block(input int d, input logic [127:0] ct,
                           input int lat);
    int at;
    push_exp(d, PT, 1'b1);
    send_block(d, ct);
    wait_ov(d, at);
    if (lat > 0 && at >= 0)
      check($sformatf("latency%0d", d), 32'(at - fire_cyc[d]), 32'(lat));
    wait_drain(d);
  endtask

  task automatic check_reset(input int d);
    check("rst_out_valid", 32'(out_valid[d]), 32'd0);
    check("rst_out_byte", 32'(out_byte[d]), 32'd0);
    check("rst_busy", 32'(busy[d]), 32'd0);
    check("rst_key_round", 32'(key_round[d]), 32'(NRV[d]));
    check("rst_in_ready", 32'(in_ready[d]), 32'(key_valid[d]));
    check("rst_key_ready", 32'(key_ready[d]), 32'(in_valid[d]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_byte[d] = 8'h00;
    end
    build_sbox();
    expand(0, {K128, 128'h0}, 4, 10);
    expand(1, K256, 8, 14);
    repeat (3) @(negedge clock);
    #1;
    check_reset(0);
    check_reset(1);
    #1 reset = 1'b0;

    // LOAD with in_valid but no key byte: nothing may be consumed
    kv_off[0] = 1'b1;
    @(negedge clock);
    in_valid[0] = 1'b1;
    in_byte[0] = 8'haa;
    repeat (4) begin
      @(negedge clock);
      #1;
      check("iso_in_ready", 32'(in_ready[0]), 32'd0);
      check("iso_busy", 32'(busy[0]), 32'd0);
    end
    @(negedge clock);
    in_valid[0] = 1'b0;
    kv_off[0] = 1'b0;

    run_block(0, CT1, 212);
    run_block(1, CT3, 292);

    kv_gap[0] = 30;
    or_gap[0] = 30;
    run_block(0, CT1, 0);
    kv_gap[0] = 0;
    or_gap[0] = 0;

    // Abort in round 5, then decrypt cleanly
    send_block(0, CT1);
    t = 0;
    while (!(key_ready[0] && key_round[0] == 4'd5) && t < 1000) begin
      @(negedge clock);
      #1;
      t++;
    end
    check("reach_rnd5", 32'(key_round[0]), 32'd5);
    #1 reset = 1'b1;
    #1;
    check_reset(0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("post_rst_busy", 32'(busy[0]), 32'd0);
    run_block(0, CT1, 212);

    // Back-to-back: second block queued behind the first
    push_exp(0, PT, 1'b1);
    push_exp(0, PT, 1'b0);
    send_block(0, CT1);
    send_block(0, CT1 ^ {8'h01, 120'h0});
    check("b2b_start", 32'(fire_cyc[0] - last_ofire[0]), 32'd1);
    wait_drain(0);

    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_serial.md
# aes_decrypt_serial

Byte-serial AES inverse cipher engine with back-pressure on every interface. It supports AES-128, AES-192 and AES-256 through the round-count parameter. Ciphertext enters one byte per cycle; round-key bytes come from an external key-schedule block indexed by `key_round`; plaintext leaves one byte per cycle. It sits between the byte-wide data path and the shared key-expansion block in the AES datapath and runs the complete inverse cipher without host sequencing.

## Interface
- `NR`, default 10: number of rounds; legal values 10, 12, 14; any other value is a synthesis-time error.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: ciphertext byte valid.
- `in_ready` output 1: ciphertext byte accepted when `in_valid & in_ready`.
- `in_byte` input 8: ciphertext byte, FIPS-197 order (byte 0 first).
- `key_valid` input 1: round-key byte valid.
- `key_ready` output 1: key byte consumed when `key_valid & key_ready`.
- `key_byte` input 8: byte j of the round key selected by `key_round`.
- `key_round` output 4: round-key index currently requested.
- `out_valid` output 1: plaintext byte valid.
- `out_ready` input 1: downstream accepts the byte.
- `out_byte` output 8: plaintext byte, FIPS-197 order.
- `busy` output 1: block in progress (any state except LOAD with index 0).

## Operation
- Byte j maps to row j%4, column j/4.
- Two 128-bit registers hold the block: `st` (state) and `wk` (work).
- A 4-bit byte/column index `idx` and a 4-bit round counter `rnd` drive the FSM.
- FSM states:
  - **LOAD**: the reset state. `rnd=NR`, `key_round=NR`.
    - `in_ready = key_valid`, `key_ready = in_valid`; both transfers fire together.
    - Each fire writes `st[idx] = in_byte ^ key_byte` and increments `idx`.
    - After byte 15: `idx=0`, `rnd=NR-1`, go to ROUND.
  - **ROUND**: `key_ready=1`, `key_round=rnd`.
    - Each cycle with `key_valid`: `wk[idx] = InvSbox(st[src]) ^ key_byte`, where `src = 4*((c-r) mod 4)+r` (InvShiftRows folded into the read address).
    - `key_valid` low stalls: no register changes.
    - After byte 15, copy `wk` into `st`. If `rnd==0`, go to OUT; otherwise go to MIX.
  - **MIX**: 4 cycles, column `idx` per cycle, in place: `st[col] = InvMixColumn(st[col])`. Never stalls.
    - After column 3: `rnd = rnd-1`, go to ROUND.
  - **OUT**: `out_valid=1`, `out_byte = st[idx]`.
    - `idx` advances only on `out_ready`.
    - After byte 15 is accepted, go to LOAD with `idx=0`.
- All `in_byte` values are accepted unchanged; there is no illegal input data.
- GF(2^8) arithmetic: xtime with reduction polynomial 0x11B; multipliers 9, 11, 13, 14.

## Timing
- Reset values:
  - `in_ready` follows `key_valid` (combinational in LOAD); `key_ready` follows `in_valid`.
  - `out_valid=0`, `out_byte=0`, `busy=0`, `key_round=NR`.
  - Internal: `st=0`, `wk=0`, `idx=0`, `rnd=NR`.
- Reset asserted mid-operation aborts the block immediately. No partial output follows. The next block starts cleanly in LOAD.
- Zero-stall latency, from the first input fire to the first `out_valid`:
  - 16 (LOAD) + (NR-1)×20 + 16 (final ROUND) cycles.
  - AES-128: 212 cycles; AES-256: 292 cycles.
- Output drain takes 16 further cycles at `out_ready=1`.
- `out_byte` is held stable while `out_valid & ~out_ready`.
- `in_ready=0` in every state except LOAD. A new block may start the cycle after the last output fire; there is no overlap between blocks.
- `key_round` changes only on ROUND entry/exit and is stable while `key_ready=1`.
- There is no combinational path from `out_ready` to `in_ready` or `key_ready`.

## Structure
- Package `aes_pkg` holds:
  - the FSM state enum;
  - the `INV_SBOX` constant array;
  - the `gmul`/`xtime` functions;
  - the InvShiftRows source-index function.
- Sub-module `inv_mix_column`: 32-bit combinational column transform, instantiated once.
- The inverse S-box is a single 8-bit lookup from the package; one instance only.

## Test plan
- **AES-128 (FIPS-197 C.1)**: key model supplies the expansion of 000102…0f; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, first `out_valid` 212 cycles after the first fire.
- **AES-256, NR=14 (FIPS-197 C.3)**: key 000102…1f; ciphertext 8ea2b7ca516745bfeafc49904b496089 -> plaintext 00112233…eeff.
- **Random stalls**: random 30% gaps on `key_valid` plus random `out_ready` on the C.1 vector -> identical plaintext; `out_byte` stable during stalls; `key_round` sequence 10,9,…,0 with no skips.
- **Mid-operation reset**: `reset` pulsed in ROUND with `rnd=5` -> all outputs take reset values; a following C.1 block decrypts correctly.
- **Back-to-back blocks**: two blocks (C.1, then the same ciphertext with byte 0 flipped) -> first plaintext exact; second block starts the cycle after the 16th output fire.
- **Handshake isolation**: `in_valid=1` with `key_valid=0` in LOAD -> `in_ready=0`, no byte consumed, `busy` stays 0.
